// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - register file, operand fetch with forwarding and write-back for the Prelude ALU.
// Optional: define PRELUDE_R0_ZERO_EN to hard-wire register 0 to zero.
module alu_operand_stage #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [AW-1:0]     in_src_a,
  input  logic [AW-1:0]     in_src_b,
  input  logic [AW-1:0]     in_dst,
  input  logic              in_we,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic [AW-1:0]     ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  output logic [5:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              ex_valid,
  output logic              wb_valid,
  output logic [AW-1:0]     wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              rst_done_q, rst_done_d;
  logic              ex_valid_q, ex_valid_d;
  logic              ex_we_q, ex_we_d;
  logic [AW-1:0]     ex_dst_q, ex_dst_d;
  logic [5:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              wb_valid_q, wb_valid_d;
  logic [AW-1:0]     wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              issue;
  logic              ext_fire;
  logic              alu_wr;
  logic              ext_wr;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  assign in_ready  = rst_done_q & ~hold;
  // A pending ALU write-back owns the register file write port this cycle.
  assign ext_ready = rst_done_q & ~(ex_valid_q & ex_we_q);
  assign issue     = in_valid & in_ready;
  assign ext_fire  = ext_valid & ext_ready;

`ifdef PRELUDE_R0_ZERO_EN
  assign alu_wr   = ex_valid_q & ex_we_q & (ex_dst_q != '0);
  assign ext_wr   = ext_fire & (ext_addr != '0);
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`else
  assign alu_wr   = ex_valid_q & ex_we_q;
  assign ext_wr   = ext_fire;
  assign dbg_data = regs_q[dbg_addr];
`endif

  // alu_wr and ext_wr never coincide, so the two bypass sources never compete.
  always_comb begin
    if (alu_wr && (ex_dst_q == in_src_a)) begin
      fwd_a = alu_result;
    end else if (ext_wr && (ext_addr == in_src_a)) begin
      fwd_a = ext_data;
    end else begin
      fwd_a = regs_q[in_src_a];
    end
    if (alu_wr && (ex_dst_q == in_src_b)) begin
      fwd_b = alu_result;
    end else if (ext_wr && (ext_addr == in_src_b)) begin
      fwd_b = ext_data;
    end else begin
      fwd_b = regs_q[in_src_b];
    end
`ifdef PRELUDE_R0_ZERO_EN
    if (in_src_a == '0) fwd_a = '0;
    if (in_src_b == '0) fwd_b = '0;
`endif
  end

  always_comb begin
    regs_d     = regs_q;
    rst_done_d = 1'b1;
    wb_valid_d = alu_wr | ext_wr;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (alu_wr) begin
      regs_d[ex_dst_q] = alu_result;
      wb_addr_d        = ex_dst_q;
      wb_data_d        = alu_result;
    end else if (ext_wr) begin
      regs_d[ext_addr] = ext_data;
      wb_addr_d        = ext_addr;
      wb_data_d        = ext_data;
    end
  end

  always_comb begin
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    ex_dst_d   = ex_dst_q;
    ex_we_d    = 1'b0;
    ex_valid_d = 1'b0;
    if (issue) begin
      alu_op_d   = in_op;
      alu_a_d    = fwd_a;
      alu_b_d    = fwd_b;
      ex_dst_d   = in_dst;
      ex_we_d    = in_we;
      ex_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rst_done_q <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_we_q    <= 1'b0;
      ex_dst_q   <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      rst_done_q <= rst_done_d;
      ex_valid_q <= ex_valid_d;
      ex_we_q    <= ex_we_d;
      ex_dst_q   <= ex_dst_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign ex_valid = ex_valid_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

endmodule
